mcycle_seq: RTL

Iterative multi-cycle arithmetic sequencer for the single-cycle ARM core. It accepts the start request and operation select from the decoder, runs an unsigned shift-add multiply or a restoring divide over WIDTH cycles, and holds the core's PC/register-file write stalled through Busy until the result is ready. The result is written back by the normal RegWrite path on the Done cycle.

---
 rtl/mcycle_pkg.sv | 6 +
 rtl/mcycle_seq_if.sv | 13 +
 rtl/mcycle_seq.sv | 78 +++++++
 3 files changed

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared state and operation encodings for the multi-cycle sequencer
package mcycle_pkg;
   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
   localparam logic MC_MUL = 1'b0;
   localparam logic MC_DIV = 1'b1;
endpackage

// File: rtl/mcycle_seq_if.sv
// mcycle_seq_if: request/result bundle between the core decoder and the multi-cycle unit
interface mcycle_seq_if #(parameter int WIDTH = 32);
   logic             Start;
   logic             MCycleOp;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result1;
   logic [WIDTH-1:0] Result2;
   logic             Busy;
   logic             Done;
   modport master (output Start, MCycleOp, Operand1, Operand2, input Result1, Result2, Busy, Done);
   modport slave (input Start, MCycleOp, Operand1, Operand2, output Result1, Result2, Busy, Done);
endinterface

// File: rtl/mcycle_seq.sv
// mcycle_seq: iterative unsigned shift-add multiply / restoring divide sharing one adder
module mcycle_seq
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic        CLK,
   input logic        RESETn,
   mcycle_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic             op;
   logic [WIDTH-1:0] hi, lo, b, r1, r2;
   logic             done;
   logic             last, is_div, div_bit;
   logic [WIDTH:0]   add_a, add_b, sum, mul_step;
   logic [WIDTH-1:0] div_hi, hi_nx, lo_nx;

   assign last   = cnt == CW'(WIDTH - 1);
   assign is_div = op == MC_DIV;
   // one WIDTH+1 bit adder: multiply adds the multiplicand, divide subtracts the divisor
   assign add_a    = is_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
   assign add_b    = is_div ? ~{1'b0, b} : {1'b0, b};
   assign sum      = add_a + add_b + {{WIDTH{1'b0}}, is_div};
   assign div_bit  = ~sum[WIDTH];
   assign div_hi   = div_bit ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
   assign mul_step = lo[0] ? sum : {1'b0, hi};
   // lo holds the multiplier (consumed from the LSB) or the dividend/quotient; hi accumulates
   assign {hi_nx, lo_nx} = is_div ? {div_hi, lo[WIDTH-2:0], div_bit} : {mul_step, lo[WIDTH-1:1]};

   assign bus.Busy    = (state == IDLE && bus.Start) || state == COMPUTE;
   assign bus.Done    = done;
   assign bus.Result1 = r1;
   assign bus.Result2 = r2;

   // state register
   always_ff @(posedge CLK)
      state <= !RESETn ? IDLE : state_nx;

   // next state: Start only matters in IDLE, DONE always returns to IDLE
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (bus.Start ? COMPUTE : IDLE) :
                 state == COMPUTE ? (last ? DONE : COMPUTE) : IDLE;
   end

   // operand capture, one iteration per COMPUTE cycle, result load on entry to DONE
   always_ff @(posedge CLK)
      if (!RESETn) begin
         cnt  <= '0;
         op   <= MC_MUL;
         hi   <= '0;
         lo   <= '0;
         b    <= '0;
         r1   <= '0;
         r2   <= '0;
         done <= 1'b0;
      end else begin
         done <= state == COMPUTE && last;
         if (state == IDLE && bus.Start) begin
            cnt <= '0;
            op  <= bus.MCycleOp;
            hi  <= '0;
            lo  <= bus.Operand1;
            b   <= bus.Operand2;
         end else if (state == COMPUTE) begin
            cnt <= cnt + CW'(1);
            hi  <= hi_nx;
            lo  <= lo_nx;
            if (last) begin
               r1 <= lo_nx;
               r2 <= hi_nx;
            end
         end
      end
endmodule
